// File: rtl/mem_rr_arbiter.sv
// Two-master round-robin arbiter in front of one pipelined memory port.
// Registered command stage, per-master outstanding-read throttling, tagged read returns.
module mem_rr_arbiter #(
  parameter logic [1:0] ID0             = 2'd1,
  parameter logic [1:0] ID1             = 2'd2,
  parameter int         MAX_OUTSTANDING = 7,
  parameter int         CNT_W           = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [29:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  input  logic [3:0]  m0_writedatamask,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  output logic        m0_readdatavalid,
  input  logic [29:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m1_writedatamask,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic        m1_readdatavalid,
  input  logic        mem_waitrequest,
  output logic [1:0]  mem_id,
  output logic [29:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_writedatamask,
  input  logic [31:0] mem_readdata,
  input  logic [1:0]  mem_readdataid,
  output logic        protocol_error
);

  localparam logic [1:0]       TAG [2] = '{ID0, ID1};
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [1:0]       rd, wr, elig, ret;
  logic             load_en, grant_vld, grant_sel;
  logic             rr_q, rr_d;
  logic             armed_q, armed_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [1:0]       id_q, id_d;
  logic [29:0]      addr_q, addr_d;
  logic             rd_q, rd_d, wr_q, wr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       mask_q, mask_d;

  assign rd  = {m1_read, m0_read};
  assign wr  = {m1_write, m0_write};
  assign ret = {mem_readdataid == TAG[1], mem_readdataid == TAG[0]};

  // A master sitting at its read limit stays eligible for writes.
  assign elig[0] = wr[0] | (rd[0] & (cnt_q[0] < CNT_MAX));
  assign elig[1] = wr[1] | (rd[1] & (cnt_q[1] < CNT_MAX));

  assign load_en   = ~(rd_q | wr_q) | ~mem_waitrequest;
  assign grant_vld = load_en & (|elig);
  // rr_q names the master that wins a tie.
  assign grant_sel = (&elig) ? rr_q : elig[1];

  assign m0_waitrequest   = ~(grant_vld & ~grant_sel);
  assign m1_waitrequest   = ~(grant_vld &  grant_sel);
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = ret[0];
  assign m1_readdatavalid = ret[1];

  // NOTE: every variable written here gets its default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    rr_d    = rr_q;
    armed_d = armed_q | grant_vld;
    err_d   = err_q;
    id_d    = id_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;

    if (grant_vld) begin
      rr_d    = ~grant_sel;
      id_d    = grant_sel ? ID1 : ID0;
      addr_d  = grant_sel ? m1_address : m0_address;
      wdata_d = grant_sel ? m1_writedata : m0_writedata;
      mask_d  = grant_sel ? m1_writedatamask : m0_writedatamask;
      // Read+write together is forwarded as a write; the read is never acknowledged.
      wr_d    = wr[grant_sel];
      rd_d    = rd[grant_sel] & ~wr[grant_sel];
      if (rd[grant_sel] & wr[grant_sel]) err_d = 1'b1;
    end else if (load_en) begin
      rd_d = 1'b0;
      wr_d = 1'b0;
    end

    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = cnt_q[i];
      if (grant_vld && (grant_sel == 1'(i)) && rd[i] && !wr[i]) begin
        if (!ret[i]) cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (ret[i]) begin
        if (cnt_q[i] != '0)            cnt_d[i] = cnt_q[i] - 1'b1;
        else if (armed_q || grant_vld) err_d    = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_q     <= 1'b0;
      armed_q  <= 1'b0;
      err_q    <= 1'b0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
      id_q     <= '0;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      mask_q   <= '0;
    end else begin
      rr_q     <= rr_d;
      armed_q  <= armed_d;
      err_q    <= err_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
      id_q     <= id_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
      mask_q   <= mask_d;
    end
  end

  assign mem_id            = id_q;
  assign mem_address       = addr_q;
  assign mem_read          = rd_q;
  assign mem_write         = wr_q;
  assign mem_writedata     = wdata_q;
  assign mem_writedatamask = mask_q;
  assign protocol_error    = err_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed self-checking bench for mem_rr_arbiter: grants, throttling, stalls, errors, reset.
module tb_mem_rr_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [29:0] m0_address, m1_address;
  logic        m0_read, m1_read, m0_write, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic [3:0]  m0_writedatamask, m1_writedatamask;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic        mem_waitrequest;
  logic [1:0]  mem_id;
  logic [29:0] mem_address;
  logic        mem_read, mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_writedatamask;
  logic [31:0] mem_readdata;
  logic [1:0]  mem_readdataid;
  logic        protocol_error;

  int n_checks = 0;
  int n_fail   = 0;

  mem_rr_arbiter dut (
    .clock(clock), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_writedatamask(m0_writedatamask),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_writedatamask(m1_writedatamask),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_waitrequest(mem_waitrequest), .mem_id(mem_id), .mem_address(mem_address),
    .mem_read(mem_read), .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_writedatamask(mem_writedatamask), .mem_readdata(mem_readdata),
    .mem_readdataid(mem_readdataid), .protocol_error(protocol_error)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_writedatamask = '0;
    m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_writedatamask = '0;
    mem_waitrequest = 0; mem_readdata = '0; mem_readdataid = '0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    reset_dut();
    n_checks++; if (mem_read !== 1'b0)       begin n_fail++; $display("FAIL reset_mem_read: got %b exp 0", mem_read); end
    n_checks++; if (mem_write !== 1'b0)      begin n_fail++; $display("FAIL reset_mem_write: got %b exp 0", mem_write); end
    n_checks++; if (mem_id !== 2'd0)         begin n_fail++; $display("FAIL reset_mem_id: got %0d exp 0", mem_id); end
    n_checks++; if (mem_address !== 30'd0)   begin n_fail++; $display("FAIL reset_mem_address: got %h exp 0", mem_address); end
    n_checks++; if (mem_writedata !== 32'd0) begin n_fail++; $display("FAIL reset_mem_writedata: got %h exp 0", mem_writedata); end
    n_checks++; if (mem_writedatamask !== 4'd0) begin n_fail++; $display("FAIL reset_mem_mask: got %h exp 0", mem_writedatamask); end
    n_checks++; if (protocol_error !== 1'b0) begin n_fail++; $display("FAIL reset_protocol_error: got %b exp 0", protocol_error); end
    n_checks++; if ({m1_waitrequest, m0_waitrequest} !== 2'b11) begin n_fail++; $display("FAIL reset_idle_wait: got %b exp 11", {m1_waitrequest, m0_waitrequest}); end
  endtask

  task automatic test_single_read();
    m0_read = 1; m0_address = 30'h100;
    #1;
    n_checks++; if (m0_waitrequest !== 1'b0) begin n_fail++; $display("FAIL single_m0_wait: got %b exp 0", m0_waitrequest); end
    n_checks++; if (m1_waitrequest !== 1'b1) begin n_fail++; $display("FAIL single_m1_wait: got %b exp 1", m1_waitrequest); end
    tick();
    m0_read = 0;
    n_checks++; if (mem_read !== 1'b1)        begin n_fail++; $display("FAIL single_mem_read: got %b exp 1", mem_read); end
    n_checks++; if (mem_address !== 30'h100)  begin n_fail++; $display("FAIL single_mem_address: got %h exp 100", mem_address); end
    n_checks++; if (mem_id !== 2'd1)          begin n_fail++; $display("FAIL single_mem_id: got %0d exp 1", mem_id); end
    mem_readdata = 32'hDEADBEEF; mem_readdataid = 2'd1;
    #1;
    n_checks++; if (m0_readdatavalid !== 1'b1) begin n_fail++; $display("FAIL return_m0_valid: got %b exp 1", m0_readdatavalid); end
    n_checks++; if (m1_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL return_m1_valid: got %b exp 0", m1_readdatavalid); end
    n_checks++; if (m1_readdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL return_m1_data: got %h exp deadbeef", m1_readdata); end
    n_checks++; if (m0_readdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL return_m0_data: got %h exp deadbeef", m0_readdata); end
    tick();
    mem_readdataid = 2'd0;
    n_checks++; if (mem_read !== 1'b0)       begin n_fail++; $display("FAIL single_idle_clear: got %b exp 0", mem_read); end
    n_checks++; if (protocol_error !== 1'b0) begin n_fail++; $display("FAIL single_no_error: got %b exp 0", protocol_error); end
  endtask

  task automatic test_back_to_back_and_stall();
    bit exp1;
    reset_dut();
    m0_write = 1; m0_address = 30'h10; m0_writedata = 32'hA0A0_0000; m0_writedatamask = 4'h3;
    m1_write = 1; m1_address = 30'h20; m1_writedata = 32'hB1B1_0000; m1_writedatamask = 4'hC;
    for (int k = 0; k < 4; k++) begin
      exp1 = (k % 2) == 1;
      #1;
      n_checks++; if (m0_waitrequest !== exp1)  begin n_fail++; $display("FAIL alt_m0_wait[%0d]: got %b exp %b", k, m0_waitrequest, exp1); end
      n_checks++; if (m1_waitrequest !== !exp1) begin n_fail++; $display("FAIL alt_m1_wait[%0d]: got %b exp %b", k, m1_waitrequest, !exp1); end
      tick();
      n_checks++; if (mem_id !== (exp1 ? 2'd2 : 2'd1)) begin n_fail++; $display("FAIL alt_id[%0d]: got %0d exp %0d", k, mem_id, exp1 ? 2 : 1); end
      n_checks++; if (mem_write !== 1'b1) begin n_fail++; $display("FAIL alt_write[%0d]: got %b exp 1", k, mem_write); end
      n_checks++; if (mem_writedata !== (exp1 ? 32'hB1B1_0000 : 32'hA0A0_0000)) begin n_fail++; $display("FAIL alt_wdata[%0d]: got %h", k, mem_writedata); end
      n_checks++; if (mem_writedatamask !== (exp1 ? 4'hC : 4'h3)) begin n_fail++; $display("FAIL alt_mask[%0d]: got %h", k, mem_writedatamask); end
    end
    mem_waitrequest = 1;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++; if ({m1_waitrequest, m0_waitrequest} !== 2'b11) begin n_fail++; $display("FAIL stall_wait[%0d]: got %b exp 11", k, {m1_waitrequest, m0_waitrequest}); end
      tick();
      n_checks++; if ({mem_id, mem_address, mem_write, mem_writedata} !== {2'd2, 30'h20, 1'b1, 32'hB1B1_0000}) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got id %0d addr %h wr %b data %h exp id 2 addr 20 wr 1 data b1b10000", k, mem_id, mem_address, mem_write, mem_writedata);
      end
    end
    mem_waitrequest = 0;
    #1;
    n_checks++; if ({m1_waitrequest, m0_waitrequest} !== 2'b10) begin n_fail++; $display("FAIL release_wait: got %b exp 10", {m1_waitrequest, m0_waitrequest}); end
    tick();
    n_checks++; if (mem_id !== 2'd1) begin n_fail++; $display("FAIL release_id: got %0d exp 1", mem_id); end
    m0_write = 0; m1_write = 0;
    tick();
    n_checks++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL drain_write: got %b exp 0", mem_write); end
  endtask

  task automatic test_throttle();
    reset_dut();
    m1_read = 1; m1_address = 30'h200;
    for (int k = 0; k < 7; k++) begin
      #1;
      n_checks++; if (m1_waitrequest !== 1'b0) begin n_fail++; $display("FAIL thr_read_wait[%0d]: got %b exp 0", k, m1_waitrequest); end
      tick();
    end
    #1;
    n_checks++; if (m1_waitrequest !== 1'b1) begin n_fail++; $display("FAIL thr_8th_stalled: got %b exp 1", m1_waitrequest); end
    m0_read = 1; m0_address = 30'h300;
    #1;
    n_checks++; if ({m1_waitrequest, m0_waitrequest} !== 2'b10) begin n_fail++; $display("FAIL thr_m0_pass: got %b exp 10", {m1_waitrequest, m0_waitrequest}); end
    tick();
    n_checks++; if ({mem_read, mem_id, mem_address} !== {1'b1, 2'd1, 30'h300}) begin n_fail++; $display("FAIL thr_m0_cmd: got rd %b id %0d addr %h exp rd 1 id 1 addr 300", mem_read, mem_id, mem_address); end
    m0_read = 0; m1_read = 0; m1_write = 1;
    #1;
    n_checks++; if (m1_waitrequest !== 1'b0) begin n_fail++; $display("FAIL thr_m1_write_wait: got %b exp 0", m1_waitrequest); end
    tick();
    n_checks++; if ({mem_write, mem_read, mem_id} !== {1'b1, 1'b0, 2'd2}) begin n_fail++; $display("FAIL thr_m1_write_cmd: got wr %b rd %b id %0d exp wr 1 rd 0 id 2", mem_write, mem_read, mem_id); end
    m1_write = 0; m1_read = 1;
    #1;
    n_checks++; if (m1_waitrequest !== 1'b1) begin n_fail++; $display("FAIL thr_still_stalled: got %b exp 1", m1_waitrequest); end
    tick();
    mem_readdataid = 2'd2;
    #1;
    n_checks++; if (m1_waitrequest !== 1'b1) begin n_fail++; $display("FAIL thr_return_cycle_wait: got %b exp 1", m1_waitrequest); end
    n_checks++; if (m1_readdatavalid !== 1'b1) begin n_fail++; $display("FAIL thr_m1_valid: got %b exp 1", m1_readdatavalid); end
    tick();
    mem_readdataid = 2'd0;
    #1;
    n_checks++; if (m1_waitrequest !== 1'b0) begin n_fail++; $display("FAIL thr_released_wait: got %b exp 0", m1_waitrequest); end
    tick();
    m1_read = 0;
    n_checks++; if ({mem_read, mem_id} !== {1'b1, 2'd2}) begin n_fail++; $display("FAIL thr_8th_cmd: got rd %b id %0d exp rd 1 id 2", mem_read, mem_id); end
  endtask

  task automatic test_same_cycle_return();
    reset_dut();
    m1_read = 1; m1_address = 30'h55;
    tick(); tick(); tick();
    mem_readdataid = 2'd2;
    tick();
    mem_readdataid = 2'd0;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++; if (m1_waitrequest !== 1'b0) begin n_fail++; $display("FAIL same_cnt_room[%0d]: got %b exp 0", k, m1_waitrequest); end
      tick();
    end
    #1;
    n_checks++; if (m1_waitrequest !== 1'b1) begin n_fail++; $display("FAIL same_cnt_full: got %b exp 1", m1_waitrequest); end
    n_checks++; if (protocol_error !== 1'b0) begin n_fail++; $display("FAIL same_no_error: got %b exp 0", protocol_error); end
    m1_read = 0;
    mem_readdataid = 2'd1;
    tick();
    mem_readdataid = 2'd0;
    n_checks++; if (protocol_error !== 1'b1) begin n_fail++; $display("FAIL underflow_error: got %b exp 1", protocol_error); end
    tick(); tick(); tick();
    n_checks++; if (protocol_error !== 1'b1) begin n_fail++; $display("FAIL error_sticky: got %b exp 1", protocol_error); end
  endtask

  task automatic test_illegal_rw();
    reset_dut();
    n_checks++; if (protocol_error !== 1'b0) begin n_fail++; $display("FAIL rw_reset_clears: got %b exp 0", protocol_error); end
    m0_read = 1; m0_write = 1; m0_address = 30'h40; m0_writedata = 32'h1234_5678; m0_writedatamask = 4'hF;
    #1;
    n_checks++; if (m0_waitrequest !== 1'b0) begin n_fail++; $display("FAIL rw_wait: got %b exp 0", m0_waitrequest); end
    tick();
    m0_read = 0; m0_write = 0;
    n_checks++; if ({mem_write, mem_read} !== 2'b10) begin n_fail++; $display("FAIL rw_as_write: got wr/rd %b exp 10", {mem_write, mem_read}); end
    n_checks++; if (mem_writedata !== 32'h1234_5678) begin n_fail++; $display("FAIL rw_wdata: got %h exp 12345678", mem_writedata); end
    n_checks++; if (protocol_error !== 1'b1) begin n_fail++; $display("FAIL rw_error: got %b exp 1", protocol_error); end
  endtask

  task automatic test_reset_midop();
    reset_dut();
    m1_read = 1; m1_address = 30'h44;
    tick();
    m1_read = 0;
    n_checks++; if (mem_read !== 1'b1) begin n_fail++; $display("FAIL midop_queued: got %b exp 1", mem_read); end
    mem_waitrequest = 1; reset = 1;
    tick();
    reset = 0; mem_waitrequest = 0;
    n_checks++; if ({mem_read, mem_id, mem_address} !== {1'b0, 2'd0, 30'd0}) begin n_fail++; $display("FAIL midop_dropped: got rd %b id %0d addr %h exp rd 0 id 0 addr 0", mem_read, mem_id, mem_address); end
    mem_readdataid = 2'd2;
    tick();
    mem_readdataid = 2'd0;
    n_checks++; if (protocol_error !== 1'b0) begin n_fail++; $display("FAIL midop_late_return: got %b exp 0", protocol_error); end
    m0_write = 1;
    tick();
    m0_write = 0;
    mem_readdataid = 2'd2;
    tick();
    mem_readdataid = 2'd0;
    n_checks++; if (protocol_error !== 1'b1) begin n_fail++; $display("FAIL midop_cnt_cleared: got %b exp 1", protocol_error); end
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    test_reset();
    test_single_read();
    test_back_to_back_and_stall();
    test_throttle();
    test_same_cycle_return();
    test_illegal_rw();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
